// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning pc, ir and datapath strobes.
// Optional single-step start input is enabled with `define CPU_SEQ_STEP_EN.
module cpu_sequencer #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
`ifdef CPU_SEQ_STEP_EN
    input  logic               i_step,
`endif
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_zero_flag,
    output logic [PC_W-1:0]    o_imem_addr,
    output logic               o_imem_rd,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_ir,
    output logic [2:0]         o_state,
    output logic               o_alu_en,
    output logic               o_rf_we,
    output logic               o_halted,
    output logic [15:0]        o_retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [15:0]        r_retire_cnt;
    logic               r_taken;
    logic               r_imem_rd;
    logic               r_alu_en;
    logic               r_rf_we;
    logic               r_halted;
    logic [3:0]         w_opcode;
    logic               w_start;

    assign w_opcode = r_ir[INSTR_W-1 -: 4];

`ifdef CPU_SEQ_STEP_EN
    logic r_step_d;
    // A held step must be released before it can start another instruction.
    assign w_start = i_run | (i_step & ~r_step_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_step_d <= 1'b0;
        else       r_step_d <= i_step;
    end
`else
    assign w_start = i_run;
`endif

    // Strobes are set on the transition into their state, so each is high exactly in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_ir         <= '0;
            r_retire_cnt <= '0;
            r_taken      <= 1'b0;
            r_imem_rd    <= 1'b0;
            r_alu_en     <= 1'b0;
            r_rf_we      <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_imem_rd <= 1'b0;
            r_alu_en  <= 1'b0;
            r_rf_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_FETCH;
                        r_imem_rd <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir     <= i_imem_rdata;
                    r_state  <= S_EXECUTE;
                    r_alu_en <= 1'b1;
                end
                S_EXECUTE: begin
                    if (w_opcode == OP_JZ) r_taken <= i_zero_flag;
                    if (w_opcode == OP_HALT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_WRITEBACK;
                        r_rf_we <= (w_opcode != OP_JMP) && (w_opcode != OP_JZ);
                    end
                end
                S_WRITEBACK: begin
                    if ((w_opcode == OP_JMP) || ((w_opcode == OP_JZ) && r_taken))
                        r_pc <= r_ir[PC_W-1:0];
                    else
                        r_pc <= r_pc + PC_W'(1);
                    r_retire_cnt <= r_retire_cnt + 16'd1;
                    if (i_run) begin
                        r_state   <= S_FETCH;
                        r_imem_rd <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_imem_addr  = r_pc;
    assign o_imem_rd    = r_imem_rd;
    assign o_pc         = r_pc;
    assign o_ir         = r_ir;
    assign o_state      = r_state;
    assign o_alu_en     = r_alu_en;
    assign o_rf_we      = r_rf_we;
    assign o_halted     = r_halted;
    assign o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: retire scoreboard plus directed boundary checks.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic        zero_flag;
    logic [15:0] rdata;
    logic [3:0]  o_imem_addr;
    logic        o_imem_rd;
    logic [3:0]  o_pc;
    logic [15:0] o_ir;
    logic [2:0]  o_state;
    logic        o_alu_en;
    logic        o_rf_we;
    logic        o_halted;
    logic [15:0] o_retire_cnt;

    logic [15:0] mem [16];

    typedef struct {
        logic [3:0] pc;
        logic       we;
    } sb_t;
    sb_t sb[$];

    int checks = 0;
    int errors = 0;

    logic       pend = 1'b0;
    logic [3:0] pend_pc = '0;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_W(4), .INSTR_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_run        (run),
`ifdef CPU_SEQ_STEP_EN
        .i_step       (step),
`endif
        .i_imem_rdata (rdata),
        .i_zero_flag  (zero_flag),
        .o_imem_addr  (o_imem_addr),
        .o_imem_rd    (o_imem_rd),
        .o_pc         (o_pc),
        .o_ir         (o_ir),
        .o_state      (o_state),
        .o_alu_en     (o_alu_en),
        .o_rf_we      (o_rf_we),
        .o_halted     (o_halted),
        .o_retire_cnt (o_retire_cnt)
    );

    // One-cycle-latency instruction memory.
    always @(posedge clk) begin
        if (o_imem_rd) rdata <= mem[o_imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each WRITEBACK pops one expected retirement; pc is compared on the following cycle.
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("sb_pc", 32'(o_pc), 32'(pend_pc));
                pend = 1'b0;
            end
            if (o_state == 3'd4) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_unexpected_retire: observed retire at pc %0h expected none", o_pc);
                end else begin
                    sb_t it;
                    it = sb.pop_front();
                    check("sb_rf_we", 32'(o_rf_we), 32'(it.we));
                    pend    = 1'b1;
                    pend_pc = it.pc;
                end
            end
        end
    end

    task automatic fill(input logic [15:0] val);
        for (int i = 0; i < 16; i++) mem[i] = val;
    endtask

    task automatic push(input logic [3:0] pc, input logic we);
        sb_t it;
        it.pc = pc;
        it.we = we;
        sb.push_back(it);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        @(negedge clk);
        check("rst_state",  32'(o_state), 0);
        check("rst_pc",     32'(o_pc), 0);
        check("rst_ir",     32'(o_ir), 0);
        check("rst_retire", 32'(o_retire_cnt), 0);
        check("rst_strobes", 32'({o_imem_rd, o_alu_en, o_rf_we, o_halted}), 0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (o_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(o_state), 32'(s));
    endtask

    task automatic wait_retire(input logic [15:0] cnt, input int budget, input string tag);
        int n = 0;
        while (o_retire_cnt !== cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(o_retire_cnt), 32'(cnt));
    endtask

    initial begin
        int rd_cnt;
        int we_cnt;
        int first_rd;
        int n;
        reset     = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        zero_flag = 1'b0;
        rdata     = '0;
        fill(16'h0000);

        // NOP stream: pc walks 0..15 and wraps.
        do_reset();
        for (int i = 0; i < 16; i++) push(4'((i + 1) % 16), 1'b1);
        run = 1'b1;
        rd_cnt = 0;
        we_cnt = 0;
        first_rd = -1;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            if (o_imem_rd) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = i;
            end
            if (o_rf_we) we_cnt++;
        end
        check("nop_first_rd", 32'(first_rd), 1);
        check("nop_rd_cnt",   32'(rd_cnt), 17);
        check("nop_we_cnt",   32'(we_cnt), 16);
        check("nop_retire",   32'(o_retire_cnt), 16);
        check("nop_pc_wrap",  32'(o_pc), 0);

        // JMP at address 2 to 7.
        do_reset();
        fill(16'h1000);
        mem[2] = 16'hC007;
        push(4'd1, 1'b1); push(4'd2, 1'b1); push(4'd7, 1'b0); push(4'd8, 1'b1);
        run = 1'b1;
        wait_retire(16'd4, 40, "jmp_retire");
        check("jmp_pc", 32'(o_pc), 8);

        // JZ taken.
        do_reset();
        mem[2] = 16'h1000;
        mem[0] = 16'hD005;
        zero_flag = 1'b1;
        push(4'd5, 1'b0);
        run = 1'b1;
        wait_retire(16'd1, 20, "jz_t_retire");
        check("jz_t_pc", 32'(o_pc), 5);
        check("jz_ir", 32'(o_ir), 32'hD005);

        // JZ not taken.
        do_reset();
        zero_flag = 1'b0;
        push(4'd1, 1'b0);
        run = 1'b1;
        wait_retire(16'd1, 20, "jz_n_retire");
        check("jz_n_pc", 32'(o_pc), 1);

        // HALT at address 3.
        do_reset();
        mem[0] = 16'h1000;
        mem[3] = 16'hF000;
        push(4'd1, 1'b1); push(4'd2, 1'b1); push(4'd3, 1'b1);
        run = 1'b1;
        wait_state(3'd5, 40, "halt_state");
        check("halt_flag",   32'(o_halted), 1);
        check("halt_pc",     32'(o_pc), 3);
        check("halt_retire", 32'(o_retire_cnt), 3);
        run = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("halt_sticky", 32'({o_state, o_pc, o_imem_rd, o_alu_en, o_rf_we, o_halted}),
              32'({3'd5, 4'd3, 4'b0001}));

        // Drop run during DECODE of pc=4; instruction still completes.
        do_reset();
        mem[3] = 16'h1000;
        for (int i = 0; i < 5; i++) push(4'(i + 1), 1'b1);
        run = 1'b1;
        n = 0;
        while (!(o_pc == 4'd4 && o_state == 3'd2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drop_at_decode", 32'({o_pc, o_state}), 32'({4'd4, 3'd2}));
        run = 1'b0;
        wait_state(3'd0, 10, "drop_idle");
        check("drop_pc",     32'(o_pc), 5);
        check("drop_retire", 32'(o_retire_cnt), 5);
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_imem_rd) rd_cnt++;
        end
        check("drop_no_rd", 32'(rd_cnt), 0);

        // Asynchronous reset during EXECUTE.
        run = 1'b1;
        wait_state(3'd3, 10, "rst_exec_state");
        check("rst_exec_alu", 32'(o_alu_en), 1);
        reset = 1'b1;
        #1;
        check("rst_async_pc",  32'(o_pc), 0);
        check("rst_async_alu", 32'(o_alu_en), 0);
        check("rst_async_st",  32'(o_state), 0);
        do_reset();

`ifdef CPU_SEQ_STEP_EN
        // Held step retires exactly one instruction; a fresh pulse retires one more.
        push(4'd1, 1'b1);
        step = 1'b1;
        repeat (10) @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        check("step_retire", 32'(o_retire_cnt), 1);
        check("step_idle",   32'(o_state), 0);
        push(4'd2, 1'b1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_retire(16'd2, 20, "step2_retire");
        wait_state(3'd0, 4, "step2_idle");
        do_reset();
`endif

        check("sb_final", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
